// File: rtl/note_scheduler.sv
// Chart playback sequencer: walks the chart ROM one step per STEP_TICKS beat ticks
// and offers each non-empty 6-track note mask to the spawner over valid/ready.
module note_scheduler #(
  parameter int ADDR_W     = 10,
  parameter int CHART_LEN  = 512,
  parameter int STEP_TICKS = 8
) (
  input  logic              OriginalClk,
  input  logic              reset,
  input  logic [3:0]        game_state,
  input  logic              beat_tick,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [5:0]        rom_data,
  output logic [5:0]        spawn_mask,
  output logic              spawn_valid,
  input  logic              spawn_ready,
  output logic [ADDR_W:0]   step_index,
  output logic [7:0]        missed_count,
  output logic              song_done
);

  localparam int CNT_W = $clog2(STEP_TICKS);
  localparam logic [CNT_W-1:0]  LAST_TICK = CNT_W'(STEP_TICKS - 1);
  localparam logic [ADDR_W:0]   END_INDEX = (ADDR_W+1)'(CHART_LEN);

  typedef enum logic [2:0] {IDLE, FETCH, CAPTURE, OFFER, WAIT_STEP, DONE} state_t;

  state_t             state;
  logic [CNT_W-1:0]   tick_cnt;
  logic               run;
  logic               clear;
  logic               active;
  logic               step_due;
  logic [ADDR_W:0]    next_index;

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  assign clear      = (game_state == 4'd0) || (game_state > 4'd3);
  assign run        = (game_state == 4'd1);
  assign active     = (state == FETCH) || (state == CAPTURE) ||
                      (state == OFFER) || (state == WAIT_STEP);
  assign step_due   = run && active && beat_tick && (tick_cnt == LAST_TICK);
  assign next_index = step_index + 1'b1;

  // Valid is gated by run so halt/ending hides a pending offer without losing it.
  assign spawn_valid = run && (state == OFFER);
  assign song_done   = (state == DONE);

  always_ff @(posedge OriginalClk) begin
    if (!reset || clear) begin
      state        <= IDLE;
      tick_cnt     <= '0;
      rom_addr     <= '0;
      spawn_mask   <= '0;
      step_index   <= '0;
      missed_count <= '0;
    end else if (run) begin
      if (active && beat_tick)
        tick_cnt <= (tick_cnt == LAST_TICK) ? '0 : tick_cnt + 1'b1;
      // A step boundary overrides the per-state progression.
      if (step_due) begin
        step_index <= next_index;
        if (state == OFFER && !spawn_ready)
          missed_count <= sat_inc8(missed_count);
        if (next_index == END_INDEX) begin
          state <= DONE;
        end else begin
          state    <= FETCH;
          rom_addr <= next_index[ADDR_W-1:0];
        end
      end else begin
        case (state)
          IDLE: begin
            state    <= FETCH;
            rom_addr <= step_index[ADDR_W-1:0];
          end
          FETCH:   state <= CAPTURE;
          CAPTURE: begin
            spawn_mask <= rom_data;
            state      <= (rom_data != 6'd0) ? OFFER : WAIT_STEP;
          end
          OFFER:   if (spawn_ready) state <= WAIT_STEP;
          default: ;
        endcase
      end
    end
  end

endmodule

// File: doc/note_scheduler.md
Name: note_scheduler

Overview:
Chart playback sequencer for the 6-track game. It follows game_state and steps through the chart ROM at a fixed number of beat ticks per chart step. Each non-empty 6-bit note mask is offered to the track spawner over a valid/ready handshake. The block freezes during halt, counts steps lost to spawner back-pressure, and flags song completion.

Parameters:
ADDR_W, 10, chart ROM address width
CHART_LEN, 512, number of chart steps (must be 1..2^ADDR_W)
STEP_TICKS, 8, beat_tick pulses per chart step (must be >= 3)

Ports:
OriginalClk  input  1  system clock; all logic on its rising edge
reset  input  1  synchronous, active-low; 0 forces all state to reset values
game_state  input  4  0 beginning, 1 ingame, 2 halt, 3 ending; other values are treated as 0
beat_tick  input  1  one-cycle pulse per beat subdivision
rom_addr  output  ADDR_W  chart ROM read address
rom_data  input  6  note mask; valid exactly 1 cycle after rom_addr is presented
spawn_mask  output  6  note mask offered to the spawner (bit n = track n)
spawn_valid  output  1  spawn_mask is valid
spawn_ready  input  1  spawner accepts the mask when high with spawn_valid
step_index  output  ADDR_W+1  index of the current chart step
missed_count  output  8  saturating count of steps dropped under back-pressure
song_done  output  1  level; high once the last step period has elapsed

Behaviour:
- Reset (reset=0), and whenever game_state is 0 or invalid:
  - state goes to IDLE.
  - rom_addr, spawn_mask, step_index, missed_count and the tick counter clear to 0.
  - spawn_valid and song_done are 0.
- States are IDLE, FETCH, CAPTURE, OFFER, WAIT_STEP and DONE.
- IDLE:
  - On game_state=1, go to FETCH.
  - game_state=2 or 3 in IDLE keeps the block in IDLE.
- FETCH (1 cycle):
  - rom_addr is driven with step_index[ADDR_W-1:0].
  - Next state is CAPTURE.
- CAPTURE (1 cycle):
  - rom_data is registered into spawn_mask.
  - Non-zero mask: go to OFFER with spawn_valid=1 from the next cycle.
  - Zero mask: go to WAIT_STEP with no offer.
- OFFER:
  - spawn_valid stays high and spawn_mask stays stable until the cycle where spawn_valid and spawn_ready are both 1.
  - On that transfer, spawn_valid drops next cycle and the state goes to WAIT_STEP.
- Tick counter:
  - Counts beat_tick pulses 0..STEP_TICKS-1 and wraps.
  - Advances in FETCH, CAPTURE, OFFER and WAIT_STEP, but only while game_state=1.
  - step_due = beat_tick and counter==STEP_TICKS-1, qualified by game_state=1.
- step_due handling:
  - step_index increments.
  - If the new step_index equals CHART_LEN, go to DONE.
  - Otherwise go to FETCH.
- step_due while in OFFER without a transfer in the same cycle:
  - The pending mask is dropped and spawn_valid goes low next cycle.
  - missed_count increments, saturating at 255.
  - Normal step advance follows.
- step_due in the same cycle as a transfer: the transfer completes and missed_count is not incremented.
- Halt (game_state=2) in any running state:
  - All state, counters and spawn_mask are frozen.
  - beat_tick is ignored.
  - spawn_valid is forced to 0 and spawn_ready is ignored.
  - On return to game_state=1, execution resumes exactly where it stopped; a pending offer re-asserts spawn_valid with the same mask.
- Ending (game_state=3) in a running state: same as halt, i.e. freeze.
- DONE:
  - song_done=1 and spawn_valid=0.
  - step_index holds at CHART_LEN.
  - The block stays in DONE until reset or game_state returns to 0.
- Latency: the first mask is visible on spawn_valid 2 cycles after game_state first reads 1 in IDLE.
- The step period is exactly STEP_TICKS beat_ticks, measured from the IDLE exit.

Test Plan:
- Reset: hold reset=0 for 3 cycles with game_state=1 and beat_tick toggling -> spawn_valid=0, song_done=0, step_index=0, missed_count=0, rom_addr=0.
- Normal offer: STEP_TICKS=4, ROM[0]=6'b100001; set game_state=1 -> rom_addr=0, then spawn_valid=1 with mask 6'b100001 two cycles later; pulse spawn_ready -> spawn_valid=0 next cycle; after 4 beat_ticks -> step_index=1 and rom_addr=1.
- Empty step: ROM[1]=0 -> spawn_valid stays 0 for the whole step; step_index reaches 2 after 4 further beat_ticks.
- Halt mid-offer: ROM[2]=6'b000110 pending with ready=0; game_state=2 for 20 cycles with 10 beat_ticks -> spawn_valid=0 and step_index stays 2; game_state=1 -> spawn_valid=1 with mask 6'b000110 and tick count unchanged.
- Back-pressure miss: hold spawn_ready=0 across a step boundary -> missed_count=1; next step's mask is offered; repeat 300 times -> missed_count stays at 255.
- End of song: CHART_LEN=3, STEP_TICKS=4 -> song_done=1 after the 12th counted beat_tick, step_index=3, no further offers; game_state=0 -> song_done=0, step_index=0, state IDLE.
